// File: rtl/cmd_exec.sv
// Command executor: accepts move/calibrate commands from the command mux, drives the
// heading/drive loop (desired heading, forward speed with ramps) and reports completion.
module cmd_exec #(
  parameter logic [9:0] FRWRD_INC    = 10'h010,
  parameter logic [9:0] MAX_SPD      = 10'h300,
  parameter int         LINES_PER_SQ = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  input  logic        heading_rdy,
  input  logic        at_hdg,
  input  logic        cntrIR,
  input  logic        cal_done,
  output logic        strt_cal,
  output logic [7:0]  dsrd_hdg,
  output logic [9:0]  frwrd,
  output logic        moving,
  output logic        fanfare,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAL     = 3'd1,
    S_HDG     = 3'd2,
    S_RAMP_UP = 3'd3,
    S_RAMP_DN = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [9:0] DN_STEP = FRWRD_INC << 1;

  state_t      r_state;
  logic [3:0]  r_op;
  logic [3:0]  r_num_sq;
  logic [7:0]  r_lines;
  logic        r_cntr_q;
  logic [9:0]  r_frwrd;
  logic [7:0]  r_hdg;

  logic        w_cntr_rise;
  logic [10:0] w_up_sum;
  logic [9:0]  w_up_spd;
  logic [9:0]  w_dn_spd;
  logic [7:0]  w_target;
  logic [7:0]  w_lines_nxt;

  assign w_cntr_rise = cntrIR & ~r_cntr_q;
  // Sum carried at 11 bits so the saturation compare can never see a wrapped value.
  assign w_up_sum    = {1'b0, r_frwrd} + {1'b0, FRWRD_INC};
  assign w_up_spd    = (w_up_sum > {1'b0, MAX_SPD}) ? MAX_SPD : w_up_sum[9:0];
  assign w_dn_spd    = (r_frwrd > DN_STEP) ? (r_frwrd - DN_STEP) : 10'd0;
  assign w_target    = {4'd0, r_num_sq} * LINES_PER_SQ[7:0];
  assign w_lines_nxt = r_lines + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= 4'd0;
      r_num_sq <= 4'd0;
      r_lines  <= 8'd0;
      r_cntr_q <= 1'b0;
      r_frwrd  <= 10'd0;
      r_hdg    <= 8'd0;
    end else begin
      r_cntr_q <= cntrIR;
      case (r_state)
        S_IDLE: begin
          if (cmd_rdy) begin
            r_op     <= cmd[15:12];
            r_num_sq <= cmd[3:0];
            case (cmd[15:12])
              4'h0: r_state <= S_CAL;
              4'h2, 4'h3: begin
                r_hdg   <= cmd[11:4];
                r_state <= S_HDG;
              end
              default: r_state <= S_DONE;
            endcase
          end
        end
        S_CAL: if (cal_done) r_state <= S_DONE;
        S_HDG: begin
          r_frwrd <= 10'd0;
          if (at_hdg) begin
            r_lines <= 8'd0;
            r_state <= (r_num_sq == 4'd0) ? S_DONE : S_RAMP_UP;
          end
        end
        S_RAMP_UP: begin
          if (heading_rdy) r_frwrd <= w_up_spd;
          if (w_cntr_rise) begin
            r_lines <= w_lines_nxt;
            if (w_lines_nxt == w_target) r_state <= S_RAMP_DN;
          end
        end
        S_RAMP_DN: begin
          if (heading_rdy) r_frwrd <= w_dn_spd;
          if (w_cntr_rise) r_lines <= w_lines_nxt;
          if (r_frwrd == 10'd0) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Acknowledge is combinational so it lands in the very cycle the command is seen;
  // masked during reset so a held cmd_rdy is not acked until reset releases.
  assign clr_cmd_rdy = ~rst & (r_state == S_IDLE) & cmd_rdy;
  assign strt_cal    = clr_cmd_rdy & (cmd[15:12] == 4'h0);
  assign send_resp   = (r_state == S_DONE);
  assign fanfare     = (r_state == S_DONE) & (r_op == 4'h3);
  assign moving      = (r_state != S_IDLE) & (r_state != S_CAL);
  assign frwrd       = r_frwrd;
  assign dsrd_hdg    = r_hdg;
  assign dbg_state   = r_state;

endmodule
